// File: rtl/gbuf_stream_reader_pkg.sv
// Shared widths and FSM encoding for the global-buffer stream reader.
package gbuf_stream_reader_pkg;

  localparam int GB_DATA_W = 16;
  localparam int GB_ADDR_W = 32;
  localparam int GB_IDX_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/gbuf_rd_fifo.sv
// Small synchronous FIFO holding captured buffer reads; head is shown combinationally.
module gbuf_rd_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  // Entries are reset so the head reads zero straight out of reset.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          mem_reg[gi] <= '0;
        else if (push && (wr_ptr_reg == PTR_W'(gi)))
          mem_reg[gi] <= push_data;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/gbuf_stream_reader.sv
// Reads a strided block from the global buffer and streams it out over valid/ready,
// using FIFO credits so the fixed 1-cycle read latency never drops a word.
module gbuf_stream_reader
  import gbuf_stream_reader_pkg::*;
#(
  parameter int DATA_W     = GB_DATA_W,
  parameter int ADDR_W     = GB_ADDR_W,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  stride,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              gb_ce,
  output logic              gb_we,
  output logic [ADDR_W-1:0] gb_addr,
  input  logic [DATA_W-1:0] gb_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [LEN_W-1:0]  stride_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  issued_reg;
  logic [LEN_W-1:0]  popped_reg;
  logic              rd_pending_reg;
  logic              done_reg;

  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    inflight;
  logic              fifo_pop;

  gbuf_rd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pending_reg),
    .push_data (gb_rdata),
    .pop       (fifo_pop),
    .head      (m_data),
    .count     (fifo_count)
  );

  // Credit check counts the read still in flight; a same-cycle pop is not credited.
  assign inflight = {1'b0, fifo_count} + (CNT_W + 1)'(rd_pending_reg);
  assign gb_ce    = (state_reg == ST_ISSUE) && (inflight <= (CNT_W + 1)'(FIFO_DEPTH - 1));
  assign gb_we    = 1'b0;
  assign gb_addr  = addr_reg;
  assign m_valid  = (fifo_count != '0);
  assign fifo_pop = m_valid && m_ready;
  assign m_last   = m_valid && (popped_reg == len_reg - LEN_W'(1));
  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;

  // Address is accumulated rather than multiplied: base + issued*stride mod 2^ADDR_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      stride_reg     <= '0;
      len_reg        <= '0;
      issued_reg     <= '0;
      popped_reg     <= '0;
      rd_pending_reg <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      rd_pending_reg <= gb_ce;
      done_reg       <= 1'b0;
      if (fifo_pop)
        popped_reg <= popped_reg + LEN_W'(1);
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            addr_reg   <= base_addr;
            stride_reg <= stride;
            len_reg    <= length;
            issued_reg <= '0;
            popped_reg <= '0;
            if (length == '0)
              done_reg <= 1'b1;
            else
              state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (gb_ce) begin
            issued_reg <= issued_reg + LEN_W'(1);
            addr_reg   <= addr_reg + ADDR_W'(stride_reg);
            if (issued_reg == len_reg - LEN_W'(1))
              state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fifo_pop && m_last) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gbuf_stream_reader.sv
// Directed bench for gbuf_stream_reader with a 1024-word buffer model behind it.
module tb_gbuf_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] stride = '0;
  logic [15:0] length = '0;
  logic        busy, done, gb_ce, gb_we, m_valid, m_last;
  logic        m_ready = 1'b0;
  logic [31:0] gb_addr;
  logic [15:0] gb_rdata = '0;
  logic [15:0] m_data;

  logic [15:0] mem [1024];

  logic [31:0] ce_q [$];
  logic [15:0] data_q [$];
  logic        last_q [$];
  int          done_cnt = 0;
  bit          we_seen = 0;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  gbuf_stream_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .stride    (stride),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .gb_ce     (gb_ce),
    .gb_we     (gb_we),
    .gb_addr   (gb_addr),
    .gb_rdata  (gb_rdata),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  // Buffer model: data is returned the cycle after the enable.
  always @(posedge clk)
    if (gb_ce) gb_rdata <= mem[gb_addr[9:0]];

  // Transaction monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (gb_ce) ce_q.push_back(gb_addr);
    if (m_valid && m_ready) begin
      data_q.push_back(m_data);
      last_q.push_back(m_last);
      $display("t=%0t word 0x%04h last=%0d", $time, m_data, m_last);
    end
    if (done) done_cnt++;
    if (gb_we) we_seen = 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    ce_q.delete();
    data_q.delete();
    last_q.delete();
    done_cnt = 0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int  n = 0;
    bit  seen = 0;
    while (!seen && n < budget) begin
      cyc;
      n++;
      if (done) seen = 1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  function automatic logic [15:0] data_at(input int i);
    return (i < data_q.size()) ? data_q[i] : 16'hxxxx;
  endfunction

  function automatic int last_count();
    int c = 0;
    foreach (last_q[i]) if (last_q[i]) c++;
    return c;
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'hAC00 | 16'(i);

    // Reset values
    cyc;
    cyc;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ce", 32'(gb_ce), 0);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_last", 32'(m_last), 0);
    check("rst_addr", gb_addr, 0);
    check("rst_data", 32'(m_data), 0);
    rst = 1'b0;
    cyc;

    // Basic: base 0x10, stride 1, length 4
    clear_mon;
    base_addr = 32'h10; stride = 16'd1; length = 16'd4; m_ready = 1'b1; start = 1'b1;
    cyc;  // cycle 1
    start = 1'b0;
    check("b_c1_ce", 32'(gb_ce), 1);
    check("b_c1_addr", gb_addr, 32'h10);
    check("b_c1_busy", 32'(busy), 1);
    check("b_c1_valid", 32'(m_valid), 0);
    cyc;  // cycle 2
    check("b_c2_addr", gb_addr, 32'h11);
    check("b_c2_valid", 32'(m_valid), 0);
    cyc;  // cycle 3
    check("b_c3_addr", gb_addr, 32'h12);
    check("b_c3_valid", 32'(m_valid), 1);
    check("b_c3_data", 32'(m_data), 32'hAC10);
    check("b_c3_last", 32'(m_last), 0);
    cyc;  // cycle 4
    check("b_c4_ce", 32'(gb_ce), 1);
    check("b_c4_addr", gb_addr, 32'h13);
    check("b_c4_data", 32'(m_data), 32'hAC11);
    cyc;  // cycle 5
    check("b_c5_ce", 32'(gb_ce), 0);
    check("b_c5_data", 32'(m_data), 32'hAC12);
    cyc;  // cycle 6
    check("b_c6_data", 32'(m_data), 32'hAC13);
    check("b_c6_last", 32'(m_last), 1);
    check("b_c6_done", 32'(done), 0);
    cyc;  // cycle 7
    check("b_c7_done", 32'(done), 1);
    check("b_c7_busy", 32'(busy), 0);
    check("b_c7_valid", 32'(m_valid), 0);
    cyc;  // cycle 8
    check("b_c8_done", 32'(done), 0);
    check("b_nwords", data_q.size(), 4);
    check("b_nce", ce_q.size(), 4);
    check("b_nlast", last_count(), 1);

    // Stride with 10-bit wrap
    clear_mon;
    base_addr = 32'h3FE; stride = 16'd3; length = 16'd3; start = 1'b1;
    cyc;
    start = 1'b0;
    wait_done("w_done", 30);
    check("w_nce", ce_q.size(), 3);
    check("w_addr0", (ce_q.size() > 0) ? ce_q[0] : 32'hx, 32'h3FE);
    check("w_addr1", (ce_q.size() > 1) ? ce_q[1] : 32'hx, 32'h401);
    check("w_addr2", (ce_q.size() > 2) ? ce_q[2] : 32'hx, 32'h404);
    check("w_data0", 32'(data_at(0)), 32'hAFFE);
    check("w_data1", 32'(data_at(1)), 32'hAC01);
    check("w_data2", 32'(data_at(2)), 32'hAC04);
    check("w_last2", (last_q.size() > 2) ? 32'(last_q[2]) : 32'hx, 1);
    check("w_nlast", last_count(), 1);

    // Backpressure: length 8, m_ready low through cycle 10
    cyc;
    clear_mon;
    base_addr = 32'h40; stride = 16'd1; length = 16'd8; m_ready = 1'b0; start = 1'b1;
    cyc;  // cycle 1
    start = 1'b0;
    cyc;  // cycle 2
    cyc;  // cycle 3
    check("bp_c3_valid", 32'(m_valid), 1);
    check("bp_c3_data", 32'(m_data), 32'hAC40);
    cyc;  // cycle 4
    check("bp_c4_ce", 32'(gb_ce), 1);
    for (int c = 5; c <= 10; c++) begin
      cyc;
      check($sformatf("bp_c%0d_ce", c), 32'(gb_ce), 0);
      check($sformatf("bp_c%0d_data", c), 32'(m_data), 32'hAC40);
      check($sformatf("bp_c%0d_last", c), 32'(m_last), 0);
    end
    check("bp_nce_stall", ce_q.size(), 4);
    cyc;  // cycle 11
    m_ready = 1'b1;
    wait_done("bp_done", 60);
    check("bp_nwords", data_q.size(), 8);
    check("bp_nce", ce_q.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("bp_data%0d", i), 32'(data_at(i)), 32'hAC40 + 32'(i));
    check("bp_last7", (last_q.size() > 7) ? 32'(last_q[7]) : 32'hx, 1);
    check("bp_nlast", last_count(), 1);

    // Zero length
    cyc;
    clear_mon;
    base_addr = 32'h80; stride = 16'd1; length = 16'd0; start = 1'b1;
    cyc;
    start = 1'b0;
    check("z_done", 32'(done), 1);
    check("z_busy", 32'(busy), 0);
    cyc;
    check("z_done_off", 32'(done), 0);
    cyc;
    check("z_nce", ce_q.size(), 0);
    check("z_ndone", done_cnt, 1);

    // Start while busy is ignored
    clear_mon;
    base_addr = 32'h100; stride = 16'd2; length = 16'd5; start = 1'b1;
    cyc;
    base_addr = 32'h200; stride = 16'd7; length = 16'd9;
    cyc;
    start = 1'b0;
    wait_done("sb_done", 40);
    check("sb_nwords", data_q.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("sb_data%0d", i), 32'(data_at(i)), 32'hAD00 + 32'(2 * i));
    check("sb_lastaddr", (ce_q.size() > 0) ? ce_q[ce_q.size() - 1] : 32'hx, 32'h108);
    check("sb_nlast", last_count(), 1);
    cyc;
    check("sb_ndone", done_cnt, 1);

    // Reset after two of six words accepted
    clear_mon;
    base_addr = 32'h20; stride = 16'd1; length = 16'd6; start = 1'b1;
    cyc;  // cycle 1
    start = 1'b0;
    cyc;  // cycle 2
    cyc;  // cycle 3
    cyc;  // cycle 4
    cyc;  // cycle 5
    check("r_accepted", data_q.size(), 2);
    rst = 1'b1;
    #1;
    check("r_busy", 32'(busy), 0);
    check("r_ce", 32'(gb_ce), 0);
    check("r_valid", 32'(m_valid), 0);
    check("r_last", 32'(m_last), 0);
    check("r_addr", gb_addr, 0);
    check("r_data", 32'(m_data), 0);
    check("r_done", 32'(done), 0);
    cyc;
    rst = 1'b0;
    cyc;
    cyc;
    check("r_nodone", done_cnt, 0);
    clear_mon;
    base_addr = 32'h30; stride = 16'd1; length = 16'd2; start = 1'b1;
    cyc;
    start = 1'b0;
    wait_done("r2_done", 30);
    check("r2_nwords", data_q.size(), 2);
    check("r2_data0", 32'(data_at(0)), 32'hAC30);
    check("r2_data1", 32'(data_at(1)), 32'hAC31);
    check("r2_nlast", last_count(), 1);
    check("we_never", 32'(we_seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
